// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing of one 16-bit adder between two requesters.
// Operands are latched on acceptance and held for CALC_CYCLES before capture.

module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module adder_share_arbiter #(
  parameter int CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_0,
  input  logic [15:0] a_0,
  input  logic [15:0] b_0,
  input  logic        cin_0,
  input  logic        req_1,
  input  logic [15:0] a_1,
  input  logic [15:0] b_1,
  input  logic        cin_1,
  output logic        grant_0,
  output logic        grant_1,
  output logic        done_0,
  output logic        done_1,
  output logic [15:0] sum,
  output logic        overflow,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic        cin_reg, cin_next;
  logic        owner_reg, owner_next;
  logic        last_owner_reg, last_owner_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] sum_reg, sum_next;
  logic        ov_reg, ov_next;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        pick;

  // The shared adder only ever sees the latched operands.
  adder_16bit u_adder (
    .a   (a_reg),
    .b   (b_reg),
    .cin (cin_reg),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      cin_reg        <= 1'b0;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      cnt_reg        <= '0;
      sum_reg        <= '0;
      ov_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      cin_reg        <= cin_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      cnt_reg        <= cnt_next;
      sum_reg        <= sum_next;
      ov_reg         <= ov_next;
    end
  end

  // On a tie, the requester that was not served last wins.
  assign pick = (req_0 && req_1) ? ~last_owner_reg : req_1;

  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    cin_next        = cin_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    cnt_next        = cnt_reg;
    sum_next        = sum_reg;
    ov_next         = ov_reg;
    case (state_reg)
      IDLE: begin
        if (req_0 || req_1) begin
          owner_next = pick;
          a_next     = pick ? a_1 : a_0;
          b_next     = pick ? b_1 : b_0;
          cin_next   = pick ? cin_1 : cin_0;
          cnt_next   = CNT_LOAD;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          sum_next        = add_sum;
          ov_next         = add_cout;
          last_owner_next = owner_reg;
          state_next      = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign grant_0  = busy && !owner_reg;
  assign grant_1  = busy && owner_reg;
  assign done_0   = (state_reg == DONE) && !owner_reg;
  assign done_1   = (state_reg == DONE) && owner_reg;
  assign sum      = sum_reg;
  assign overflow = ov_reg;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: two instances (CALC_CYCLES 1 and 3), a timeline model,
// a per-cycle compare process and directed transactions with literal expectations.
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // Index 0 -> CALC_CYCLES=1 instance, index 1 -> CALC_CYCLES=3 instance.
  logic        r0[2], r1[2], c0[2], c1[2];
  logic [15:0] a0[2], b0[2], a1[2], b1[2];
  logic        g0[2], g1[2], d0[2], d1[2], ov[2], bs[2];
  logic [15:0] sm[2];

  int compared = 0;
  int errors   = 0;

  adder_share_arbiter #(.CALC_CYCLES(1)) dut_c1 (
    .clk(clk), .n_rst(n_rst),
    .req_0(r0[0]), .a_0(a0[0]), .b_0(b0[0]), .cin_0(c0[0]),
    .req_1(r1[0]), .a_1(a1[0]), .b_1(b1[0]), .cin_1(c1[0]),
    .grant_0(g0[0]), .grant_1(g1[0]), .done_0(d0[0]), .done_1(d1[0]),
    .sum(sm[0]), .overflow(ov[0]), .busy(bs[0])
  );

  adder_share_arbiter #(.CALC_CYCLES(3)) dut_c3 (
    .clk(clk), .n_rst(n_rst),
    .req_0(r0[1]), .a_0(a0[1]), .b_0(b0[1]), .cin_0(c0[1]),
    .req_1(r1[1]), .a_1(a1[1]), .b_1(b1[1]), .cin_1(c1[1]),
    .grant_0(g0[1]), .grant_1(g1[1]), .done_0(d0[1]), .done_1(d1[1]),
    .sum(sm[1]), .overflow(ov[1]), .busy(bs[1])
  );

  // Model: age = cycles since acceptance (-1 when idle); the result is known at
  // acceptance and becomes visible when age reaches the settle count.
  int          m_age[2]  = '{-1, -1};
  logic        m_own[2]  = '{1'b0, 1'b0};
  logic        m_last[2] = '{1'b1, 1'b1};
  logic [16:0] m_pend[2] = '{17'd0, 17'd0};
  logic [15:0] m_sum[2]  = '{16'd0, 16'd0};
  logic        m_ov[2]   = '{1'b0, 1'b0};

  function automatic int calc_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    for (int g = 0; g < 2; g++) begin
      if (!n_rst) begin
        m_age[g]  <= -1;
        m_own[g]  <= 1'b0;
        m_last[g] <= 1'b1;
        m_pend[g] <= '0;
        m_sum[g]  <= '0;
        m_ov[g]   <= 1'b0;
      end else if (m_age[g] >= 0) begin
        if (m_age[g] + 1 == calc_of(g)) begin
          m_sum[g]  <= m_pend[g][15:0];
          m_ov[g]   <= m_pend[g][16];
          m_last[g] <= m_own[g];
        end
        m_age[g] <= (m_age[g] == calc_of(g)) ? -1 : m_age[g] + 1;
      end else if (r0[g] || r1[g]) begin
        if (r0[g] && r1[g] ? !m_last[g] : r1[g]) begin
          m_own[g]  <= 1'b1;
          m_pend[g] <= {1'b0, a1[g]} + {1'b0, b1[g]} + {16'd0, c1[g]};
        end else begin
          m_own[g]  <= 1'b0;
          m_pend[g] <= {1'b0, a0[g]} + {1'b0, b0[g]} + {16'd0, c0[g]};
        end
        m_age[g] <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outputs compared against the model on every falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      automatic logic e_busy = (m_age[g] >= 0);
      automatic logic e_done = (m_age[g] == calc_of(g));
      automatic logic [24:0] act = {bs[g], g0[g], g1[g], d0[g], d1[g], ov[g], sm[g], 3'd0};
      automatic logic [24:0] exp = {e_busy, e_busy && !m_own[g], e_busy && m_own[g],
                                    e_done && !m_own[g], e_done && m_own[g],
                                    m_ov[g], m_sum[g], 3'd0};
      compared++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_cmp inst%0d: got busy/g0/g1/d0/d1/ov/sum=%b/%b/%b/%b/%b/%b/%h required %b/%b/%b/%b/%b/%b/%h at %0t",
                 g, bs[g], g0[g], g1[g], d0[g], d1[g], ov[g], sm[g],
                 exp[24], exp[23], exp[22], exp[21], exp[20], exp[19], exp[18:3], $time);
      end
    end
  end

  task automatic set_req(input int g, input int p, input logic r,
                         input logic [15:0] a, input logic [15:0] b, input logic c);
    if (p == 0) begin r0[g] = r; a0[g] = a; b0[g] = b; c0[g] = c; end
    else        begin r1[g] = r; a1[g] = a; b1[g] = b; c1[g] = c; end
  endtask

  task automatic wait_done(input int g, output int which, output int cyc, output int bcnt);
    which = -1; cyc = 0; bcnt = 0;
    for (int i = 0; i < 40 && which < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (bs[g]) bcnt++;
      if (d0[g]) which = 0;
      else if (d1[g]) which = 1;
    end
    if (which < 0) begin
      compared++;
      errors++;
      $display("FAIL done_timeout inst%0d: got no done pulse required one within 40 cycles", g);
    end
    $display("txn inst%0d: done_%0d after %0d cycles sum=%h ov=%b", g, which, cyc, sm[g], ov[g]);
  endtask

  task automatic drop_req(input int g, input int p);
    @(posedge clk); #1;
    if (p == 0) r0[g] = 1'b0; else r1[g] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  int which, cyc, bcnt;

  initial begin
    n_rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      r0[g] = 0; r1[g] = 0; c0[g] = 0; c1[g] = 0;
      a0[g] = 0; b0[g] = 0; a1[g] = 0; b1[g] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bs[0]}, 32'd0);
    chk("reset_sum", {16'd0, sm[1]}, 32'd0);
    n_rst = 1'b1;

    // Single request, wrap to zero with carry-out.
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(0, which, cyc, bcnt);
    chk("t1_who", which, 0);
    chk("t1_latency", cyc, 3);
    chk("t1_sum", {16'd0, sm[0]}, 32'h0000);
    chk("t1_ov", {31'd0, ov[0]}, 32'd1);
    drop_req(0, 0);

    // Simultaneous requests after reset: requester 0 first, then 1, then 0 again.
    do_reset();
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 16'h1234, 16'h1111, 1'b1);
    set_req(0, 1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    wait_done(0, which, cyc, bcnt);
    chk("t2_first", which, 0);
    chk("t2_sum0", {16'd0, sm[0]}, 32'h2346);
    chk("t2_ov0", {31'd0, ov[0]}, 32'd0);
    drop_req(0, 0);
    wait_done(0, which, cyc, bcnt);
    chk("t2_second", which, 1);
    chk("t2_sum1", {16'd0, sm[0]}, 32'h0000);
    chk("t2_ov1", {31'd0, ov[0]}, 32'd1);
    drop_req(0, 1);
    set_req(0, 0, 1'b1, 16'h0010, 16'h0020, 1'b0);
    set_req(0, 1, 1'b1, 16'h0100, 16'h0200, 1'b0);
    wait_done(0, which, cyc, bcnt);
    chk("t2_third", which, 0);
    chk("t2_sum2", {16'd0, sm[0]}, 32'h0030);
    drop_req(0, 0);
    wait_done(0, which, cyc, bcnt);
    chk("t2_fourth", which, 1);
    chk("t2_sum3", {16'd0, sm[0]}, 32'h0300);
    drop_req(0, 1);

    // Operand stability: a_0 changes right after acceptance.
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 16'h0005, 16'h0003, 1'b0);
    @(posedge clk); #1;
    a0[0] = 16'hAAAA;
    wait_done(0, which, cyc, bcnt);
    chk("t3_sum", {16'd0, sm[0]}, 32'h0008);
    drop_req(0, 0);

    // CALC_CYCLES=3: longer latency, busy for four cycles, operands held throughout.
    @(posedge clk); #1;
    set_req(1, 0, 1'b1, 16'h0100, 16'h0023, 1'b1);
    @(posedge clk); #1;
    a0[1] = 16'hAAAA;
    wait_done(1, which, cyc, bcnt);
    chk("t4_who", which, 0);
    chk("t4_latency", cyc, 4);
    chk("t4_busy_cycles", bcnt, 4);
    chk("t4_sum", {16'd0, sm[1]}, 32'h0124);
    drop_req(1, 0);

    // Reset while requester 1 is mid-calculation.
    @(posedge clk); #1;
    set_req(1, 1, 1'b1, 16'h0001, 16'h0002, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_grant1", {31'd0, g1[1]}, 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("t5_async_busy", {31'd0, bs[1]}, 32'd0);
    chk("t5_async_grant", {31'd0, g1[1]}, 32'd0);
    chk("t5_async_sum", {16'd0, sm[1]}, 32'h0000);
    set_req(1, 0, 1'b1, 16'h0007, 16'h0008, 1'b0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    wait_done(1, which, cyc, bcnt);
    chk("t5_first", which, 0);
    chk("t5_sum0", {16'd0, sm[1]}, 32'h000F);
    drop_req(1, 0);
    wait_done(1, which, cyc, bcnt);
    chk("t5_second", which, 1);
    chk("t5_sum1", {16'd0, sm[1]}, 32'h0003);
    drop_req(1, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Time-shares a single adder_16bit instance between two requesters using round-robin arbitration.
- Latches the winning requester's operands into internal registers and holds them for a programmable settle time.
- Captures the adder's sum and overflow into registers, then signals completion to the owning requester.
- Sits between two client blocks and the shared 16-bit adder datapath.

Parameters:
CALC_CYCLES, 1, number of clock cycles the latched operands are applied to the adder before capture; legal range 1..15, held in a 4-bit down-counter.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
req_0  input  1  requester 0 request, level.
a_0  input  16  requester 0 operand A.
b_0  input  16  requester 0 operand B.
cin_0  input  1  requester 0 carry-in.
req_1  input  1  requester 1 request, level.
a_1  input  16  requester 1 operand A.
b_1  input  16  requester 1 operand B.
cin_1  input  1  requester 1 carry-in.
grant_0  output  1  requester 0 owns the adder (CALC and DONE states).
grant_1  output  1  requester 1 owns the adder.
done_0  output  1  one-cycle pulse: result valid for requester 0.
done_1  output  1  one-cycle pulse: result valid for requester 1.
sum  output  16  registered result; holds until the next capture.
overflow  output  1  registered adder carry-out; holds until the next capture.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset n_rst.
- Reset value: state IDLE; all outputs 0; operand registers 0; counter 0; last_owner = 1, so requester 0 has first priority.
- All outputs are registered or decoded from state registers only; no combinational input-to-output path.
- States: IDLE, CALC, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, one request: that requester wins.
- IDLE, both requests high: the requester != last_owner wins.
- IDLE, on acceptance: latch a_x, b_x, cin_x and the owner; load counter with CALC_CYCLES-1; go to CALC; grant_x=1.
- CALC: the adder is driven only from the latched operand registers. Input changes after acceptance have no effect.
- CALC, counter != 0: decrement.
- CALC, counter == 0: capture adder sum and overflow into sum/overflow; set last_owner = owner; go to DONE; done_owner=1.
- DONE: lasts exactly one cycle, then IDLE; grant_x and done_x drop on that edge.
- Latency: accept edge E0 → done_x high during the cycle after edge E(CALC_CYCLES).
- Back-to-back transactions are separated by at least one IDLE cycle.
- Requester protocol: hold req_x until done_x is sampled high; drop req_x on that same edge.
- If req_x is still high in the following IDLE cycle, it counts as a new request.
- Requests arriving during CALC/DONE are not lost; they are evaluated in the next IDLE cycle.
- Arithmetic: {overflow, sum} = a + b + cin, 17 bits; wraps modulo 2^16 with overflow as the carry-out.
- Reset mid-operation: abort immediately; no done pulse; return to reset values, including the priority reset.

Test Plan:
- Reset: assert n_rst=0 mid-run → all outputs 0, busy=0 asynchronously, without waiting for a clock.
- Single request, CALC_CYCLES=1: req_0, a_0=0xFFFF, b_0=0x0001, cin_0=0 → grant_0 after E0; done_0 high after E1 for 1 cycle; sum=0x0000, overflow=1.
- Simultaneous requests after reset: req_0 (0x1234+0x1111+1), req_1 (0x8000+0x8000+0) → done_0 first with sum=0x2346, ov=0; then done_1 with sum=0x0000, ov=1. Next simultaneous pair → requester 0 served first again.
- Operand stability: change a_0 to 0xAAAA one cycle after acceptance of 0x0005+0x0003 → sum=0x0008.
- CALC_CYCLES=3: accept at E0 → done pulse appears only after E3; busy high for 4 cycles.
- Reset during CALC of requester 1: no done_1 pulse. With both requests held after reset release → requester 0 granted first.
